// File: rtl/jtag_bus_bridge_pkg.sv
// Shared JTAG memory-map offsets: TAP instruction codes, status word bit positions
// and the decoded host-command type used by the bus bridge.
package jtag_bus_bridge_pkg;

  localparam logic [31:0] JTAG_INST_IDCODE = 32'h01;
  localparam logic [31:0] JTAG_INST_BYPASS = 32'hFF;
  localparam logic [31:0] JTAG_INST_ADDR   = 32'h10;
  localparam logic [31:0] JTAG_INST_WDATA  = 32'h11;
  localparam logic [31:0] JTAG_INST_READ   = 32'h12;
  localparam logic [31:0] JTAG_INST_STATUS = 32'h13;

  localparam int unsigned JTAG_STAT_BUSY_BIT    = 0;
  localparam int unsigned JTAG_STAT_ERROR_BIT   = 1;
  localparam int unsigned JTAG_STAT_OVERRUN_BIT = 2;

  typedef enum logic [2:0] {
    JCMD_NONE,
    JCMD_ADDR,
    JCMD_WDATA,
    JCMD_READ,
    JCMD_STATUS
  } jtag_cmd_e;

  function automatic jtag_cmd_e jtag_decode_inst(input logic [31:0] ir);
    case (ir)
      JTAG_INST_ADDR:   return JCMD_ADDR;
      JTAG_INST_WDATA:  return JCMD_WDATA;
      JTAG_INST_READ:   return JCMD_READ;
      JTAG_INST_STATUS: return JCMD_STATUS;
      default:          return JCMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/jtag_bus_bridge_pulse_sync.sv
// Synchronizes a slow level/strobe from another clock domain and emits a single
// registered clk-cycle pulse on its rising edge.
module jtag_pulse_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;
  logic                   pulse_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      last_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_i};
      last_q  <= sync_q[SYNC_STAGES-1];
      pulse_q <= sync_q[SYNC_STAGES-1] & ~last_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/jtag_bus_bridge.sv
// Turns JTAG user-instruction DR updates into single-beat bus reads/writes and
// presents address, data and status back to the TAP capture path.
module jtag_bus_bridge
  import jtag_bus_bridge_pkg::*;
#(
  parameter int IR_WIDTH       = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IR_WIDTH-1:0]   jtag_ir,
  input  logic                  jtag_dr_update,
  input  logic [DATA_WIDTH-1:0] jtag_dr_value,
  output logic [DATA_WIDTH-1:0] jtag_dr_capture,
  output logic                  bus_req,
  output logic                  bus_write,
  output logic [DATA_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ready,
  input  logic                  bus_resp_valid,
  input  logic [DATA_WIDTH-1:0] bus_resp_rdata,
  input  logic                  bus_resp_error,
  output logic                  busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  ovr_q, ovr_d;
  logic [TO_W-1:0]       cnt_q, cnt_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_write_q, bus_write_d;
  logic [DATA_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] capture_q, capture_d;

  logic                  cmd;
  jtag_cmd_e             cmd_kind;
  logic                  timeout;
  logic                  done;
  logic [DATA_WIDTH-1:0] status_w;

  jtag_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_update_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (jtag_dr_update),
    .pulse_o (cmd)
  );

  // IR and DR value are quasi-static by the time cmd fires, so no synchronizer.
  assign cmd_kind = cmd ? jtag_decode_inst(32'(jtag_ir)) : JCMD_NONE;
  assign timeout  = (cnt_q >= TO_MAX);

  always_comb begin
    status_w = '0;
    status_w[JTAG_STAT_BUSY_BIT]    = busy_q;
    status_w[JTAG_STAT_ERROR_BIT]   = err_q;
    status_w[JTAG_STAT_OVERRUN_BIT] = ovr_q;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    ovr_d       = ovr_q;
    cnt_d       = cnt_q;
    bus_write_d = bus_write_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        case (cmd_kind)
          JCMD_ADDR: addr_d = jtag_dr_value;
          JCMD_WDATA: begin
            wdata_d     = jtag_dr_value;
            state_d     = ST_REQ;
            bus_write_d = 1'b1;
            bus_addr_d  = addr_q;
            bus_wdata_d = jtag_dr_value;
          end
          JCMD_READ: begin
            state_d     = ST_REQ;
            bus_write_d = 1'b0;
            bus_addr_d  = addr_q;
            bus_wdata_d = wdata_q;
          end
          JCMD_STATUS: begin
            if (jtag_dr_value[0]) begin
              err_d = 1'b0;
              ovr_d = 1'b0;
            end
          end
          default: ;
        endcase
      end
      ST_REQ: begin
        // Acceptance wins over timeout when both land on the same cycle.
        if (bus_ready) begin
          state_d = ST_WAIT;
        end else if (timeout) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          done    = 1'b1;
        end
        if (!timeout) cnt_d = cnt_q + 1'b1;
      end
      ST_WAIT: begin
        if (bus_resp_valid) begin
          state_d = ST_IDLE;
          err_d   = err_q | bus_resp_error;
          done    = 1'b1;
          if (!bus_write_q) rdata_d = bus_resp_rdata;
        end else if (timeout) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          done    = 1'b1;
        end
        if (!timeout) cnt_d = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (cmd && state_q != ST_IDLE) ovr_d = 1'b1;
    if (done) addr_d = addr_q + DATA_WIDTH'(4);

    bus_req_d = (state_d == ST_REQ);
    busy_d    = (state_d != ST_IDLE);

    case (32'(jtag_ir))
      JTAG_INST_ADDR:   capture_d = addr_q;
      JTAG_INST_READ:   capture_d = rdata_q;
      JTAG_INST_STATUS: capture_d = status_w;
      JTAG_INST_WDATA:  capture_d = wdata_q;
      default:          capture_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      ovr_q       <= 1'b0;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_write_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      busy_q      <= 1'b0;
      capture_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      ovr_q       <= ovr_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_write_q <= bus_write_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      busy_q      <= busy_d;
      capture_q   <= capture_d;
    end
  end

  assign jtag_dr_capture = capture_q;
  assign bus_req         = bus_req_q;
  assign bus_write       = bus_write_q;
  assign bus_addr        = bus_addr_q;
  assign bus_wdata       = bus_wdata_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_jtag_bus_bridge.sv
// Directed bench for jtag_bus_bridge: vector table for single commands plus
// hand-written overrun, timeout and reset-mid-transaction sequences.
module tb_jtag_bus_bridge;

  localparam logic [7:0] I_ADDR   = 8'h10;
  localparam logic [7:0] I_WDATA  = 8'h11;
  localparam logic [7:0] I_READ   = 8'h12;
  localparam logic [7:0] I_STATUS = 8'h13;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  jtag_ir;
  logic        jtag_dr_update;
  logic [31:0] jtag_dr_value;
  logic [31:0] jtag_dr_capture;
  logic        bus_req, bus_write, busy;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ready, bus_resp_valid, bus_resp_error;
  logic [31:0] bus_resp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtag_bus_bridge dut (
    .clk             (clk),
    .rst             (rst),
    .jtag_ir         (jtag_ir),
    .jtag_dr_update  (jtag_dr_update),
    .jtag_dr_value   (jtag_dr_value),
    .jtag_dr_capture (jtag_dr_capture),
    .bus_req         (bus_req),
    .bus_write       (bus_write),
    .bus_addr        (bus_addr),
    .bus_wdata       (bus_wdata),
    .bus_ready       (bus_ready),
    .bus_resp_valid  (bus_resp_valid),
    .bus_resp_rdata  (bus_resp_rdata),
    .bus_resp_error  (bus_resp_error),
    .busy            (busy)
  );

  typedef struct {
    logic [7:0]  ir;
    logic [31:0] dr;
    bit          is_bus;
    bit          exp_write;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    int          ready_dly;
    int          resp_dly;
    logic [31:0] rdata;
    bit          resp_err;
    logic [31:0] exp_status;
    logic [7:0]  cap_ir;
    logic [31:0] exp_cap;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic do_update(input logic [7:0] ir, input logic [31:0] dr);
    @(negedge clk);
    jtag_ir        = ir;
    jtag_dr_value  = dr;
    jtag_dr_update = 1'b1;
    repeat (3) @(negedge clk);
    jtag_dr_update = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (bus_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, bus_req}, 32'd1);
  endtask

  task automatic capture(input logic [7:0] ir, output logic [31:0] data);
    @(negedge clk);
    jtag_ir = ir;
    repeat (2) @(negedge clk);
    data = jtag_dr_capture;
  endtask

  task automatic pulse_ready();
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
  endtask

  task automatic pulse_resp(input logic [31:0] rdata, input bit err);
    bus_resp_valid = 1'b1;
    bus_resp_rdata = rdata;
    bus_resp_error = err;
    @(negedge clk);
    bus_resp_valid = 1'b0;
    bus_resp_error = 1'b0;
  endtask

  initial begin
    logic [31:0] cap;
    int n;

    rst = 1'b1;
    jtag_ir = 8'h00;
    jtag_dr_update = 1'b0;
    jtag_dr_value = 32'h0;
    bus_ready = 1'b0;
    bus_resp_valid = 1'b0;
    bus_resp_rdata = 32'h0;
    bus_resp_error = 1'b0;

    //           ir        dr            bus wr  addr          wdata         rd rs rdata    er status cap_ir    exp_cap
    vecs[0] = '{I_ADDR,   32'h1000_0000, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,  0, 32'h0, I_ADDR,   32'h1000_0000};
    vecs[1] = '{I_WDATA,  32'hDEAD_BEEF, 1, 1, 32'h1000_0000, 32'hDEAD_BEEF, 2, 1, 32'h0,  0, 32'h0, I_ADDR,   32'h1000_0004};
    vecs[2] = '{I_ADDR,   32'h0000_0200, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,  0, 32'h0, I_WDATA,  32'hDEAD_BEEF};
    vecs[3] = '{I_READ,   32'h0000_AAAA, 1, 0, 32'h0000_0200, 32'h0,         0, 0, 32'h11, 0, 32'h0, I_READ,   32'h11};
    vecs[4] = '{I_READ,   32'h0,         1, 0, 32'h0000_0204, 32'h0,         1, 3, 32'h22, 0, 32'h0, I_READ,   32'h22};
    vecs[5] = '{I_ADDR,   32'hFFFF_FFFC, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,  0, 32'h0, I_ADDR,   32'hFFFF_FFFC};
    vecs[6] = '{I_READ,   32'h0,         1, 0, 32'hFFFF_FFFC, 32'h0,         0, 1, 32'h33, 1, 32'h2, I_ADDR,   32'h0};
    vecs[7] = '{I_STATUS, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0, 32'h0,  0, 32'h2, I_READ,   32'h33};
    vecs[8] = '{I_STATUS, 32'h1,         0, 0, 32'h0,         32'h0,         0, 0, 32'h0,  0, 32'h0, 8'h55,    32'h0};
    vecs[9] = '{8'h01,    32'h123,       0, 0, 32'h0,         32'h0,         0, 0, 32'h0,  0, 32'h0, I_ADDR,   32'h0};

    repeat (3) @(negedge clk);
    check("rst_bus_req",   {31'd0, bus_req},   32'd0);
    check("rst_bus_write", {31'd0, bus_write}, 32'd0);
    check("rst_bus_addr",  bus_addr,           32'd0);
    check("rst_bus_wdata", bus_wdata,          32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_capture",   jtag_dr_capture,    32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      do_update(vecs[i].ir, vecs[i].dr);
      if (vecs[i].is_bus) begin
        wait_req($sformatf("v%0d_req", i));
        check($sformatf("v%0d_write", i), {31'd0, bus_write}, {31'd0, vecs[i].exp_write});
        check($sformatf("v%0d_addr", i), bus_addr, vecs[i].exp_addr);
        if (vecs[i].exp_write) check($sformatf("v%0d_wdata", i), bus_wdata, vecs[i].exp_wdata);
        check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
        repeat (vecs[i].ready_dly) @(negedge clk);
        pulse_ready();
        check($sformatf("v%0d_req_drop", i), {31'd0, bus_req}, 32'd0);
        repeat (vecs[i].resp_dly) @(negedge clk);
        pulse_resp(vecs[i].rdata, vecs[i].resp_err);
        check($sformatf("v%0d_idle", i), {31'd0, busy}, 32'd0);
      end else begin
        repeat (8) @(negedge clk);
      end
      capture(I_STATUS, cap);
      check($sformatf("v%0d_status", i), cap, vecs[i].exp_status);
      capture(vecs[i].cap_ir, cap);
      check($sformatf("v%0d_capture", i), cap, vecs[i].exp_cap);
    end

    // Overrun: second READ while the first is still waiting for bus_ready.
    do_update(I_ADDR, 32'h300);
    repeat (8) @(negedge clk);
    do_update(I_READ, 32'h0);
    wait_req("ovr_req");
    check("ovr_addr", bus_addr, 32'h300);
    do_update(I_READ, 32'h0);
    repeat (8) @(negedge clk);
    check("ovr_req_held", {31'd0, bus_req}, 32'd1);
    check("ovr_addr_held", bus_addr, 32'h300);
    capture(I_STATUS, cap);
    check("ovr_status", cap, 32'h5);
    capture(I_ADDR, cap);
    check("ovr_addr_reg", cap, 32'h300);
    @(negedge clk);
    bus_ready = 1'b1;
    bus_resp_valid = 1'b1;
    bus_resp_rdata = 32'h77;
    @(negedge clk);
    bus_ready = 1'b0;
    bus_resp_valid = 1'b0;
    check("same_cycle_resp_ignored", {31'd0, busy}, 32'd1);
    pulse_resp(32'h88, 1'b0);
    check("ovr_idle", {31'd0, busy}, 32'd0);
    capture(I_READ, cap);
    check("ovr_rdata", cap, 32'h88);
    capture(I_STATUS, cap);
    check("ovr_status_done", cap, 32'h4);
    do_update(I_STATUS, 32'h1);
    repeat (8) @(negedge clk);
    capture(I_STATUS, cap);
    check("ovr_cleared", cap, 32'h0);
    capture(I_ADDR, cap);
    check("ovr_addr_inc", cap, 32'h304);

    // Timeout: bus_ready never comes.
    do_update(I_ADDR, 32'h400);
    repeat (8) @(negedge clk);
    do_update(I_READ, 32'h0);
    wait_req("to_req");
    n = 0;
    while (bus_req === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check("to_req_cycles", n, 32'd1024);
    check("to_busy", {31'd0, busy}, 32'd0);
    capture(I_STATUS, cap);
    check("to_status", cap, 32'h2);
    capture(I_ADDR, cap);
    check("to_addr_inc", cap, 32'h404);
    do_update(I_STATUS, 32'h1);
    repeat (8) @(negedge clk);

    // Asynchronous reset while waiting for a response.
    do_update(I_READ, 32'h0);
    wait_req("rst_op_req");
    check("rst_op_addr", bus_addr, 32'h404);
    jtag_ir = I_STATUS;
    pulse_ready();
    @(negedge clk);
    check("rst_op_cap_busy", jtag_dr_capture, 32'h1);
    rst = 1'b1;
    #1;
    check("rst_op_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_op_busy", {31'd0, busy}, 32'd0);
    check("rst_op_capture", jtag_dr_capture, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_update(I_READ, 32'h0);
    wait_req("post_rst_req");
    check("post_rst_addr", bus_addr, 32'h0);
    pulse_ready();
    pulse_resp(32'h99, 1'b0);
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtag_bus_bridge.md
# jtag_bus_bridge

System-clock-domain stage that sits directly downstream of the JTAG TAP controller. It consumes the TAP's instruction register value, its DR update strobe and its 32-bit DR parallel value. It turns host commands into single-beat memory-bus read/write transactions, and returns read data and status on the TAP's DR capture input. It is the only path from the debug host into the system bus.

## Interface
Parameters:
- IR_WIDTH, 8, width of TAP instruction register
- DATA_WIDTH, 32, DR / bus address / bus data width
- SYNC_STAGES, 2, flops in the update-strobe synchronizer (≥2)
- TIMEOUT_CYCLES, 1024, clk cycles to wait for a bus response before flagging error

Ports:
- clk  in  1  system clock; the only clock of this block
- rst  in  1  asynchronous, active-high reset
- jtag_ir  in  IR_WIDTH  current TAP instruction (TCK domain, stable between Update-IR events)
- jtag_dr_update  in  1  TAP Update-DR enable for user instructions (TCK domain, high for one TCK)
- jtag_dr_value  in  DATA_WIDTH  TAP DR parallel output (stable after update)
- jtag_dr_capture  out  DATA_WIDTH  word loaded by TAP at Capture-DR
- bus_req  out  1  request valid
- bus_write  out  1  1 = write, 0 = read
- bus_addr  out  DATA_WIDTH  byte address
- bus_wdata  out  DATA_WIDTH  write data
- bus_ready  in  1  request accepted this cycle
- bus_resp_valid  in  1  response valid
- bus_resp_rdata  in  DATA_WIDTH  read data
- bus_resp_error  in  1  response carries error
- busy  out  1  transaction in flight

## Operation
- Instruction codes (user space, distinct from IDCODE/BYPASS): INST_ADDR 0x10, INST_WDATA 0x11, INST_READ 0x12, INST_STATUS 0x13.
- jtag_dr_update passes through a SYNC_STAGES synchronizer, then a rising-edge detector → one-clk `cmd` pulse. jtag_ir and jtag_dr_value are sampled unsynchronized at `cmd`; they are quasi-static by then.
- On `cmd` in IDLE:
  - INST_ADDR: addr_reg ← dr_value.
  - INST_WDATA: wdata_reg ← dr_value; start write.
  - INST_READ: start read; dr_value ignored.
  - INST_STATUS: if dr_value[0]=1, clear sticky error and overrun.
  - Other codes: ignored.
- FSM states:
  - IDLE: start → REQ.
  - REQ: bus_req=1. On bus_ready → WAIT.
  - WAIT: on bus_resp_valid → IDLE. For reads, rdata_reg ← bus_resp_rdata. error |= bus_resp_error. If timeout counter reaches TIMEOUT_CYCLES-1 first → error=1, → IDLE.
- Timeout counter also runs in REQ; a stuck bus_ready terminates the same way (bus_req deasserts).
- On every completion (ok, error or timeout): addr_reg += 4, modulo 2^DATA_WIDTH (wraps 0xFFFFFFFC→0).
- `cmd` while not IDLE: command dropped, addr/wdata unchanged, overrun=1 (sticky).
- Status word: bit0 busy, bit1 error, bit2 overrun, others 0.
- jtag_dr_capture mux on jtag_ir:
  - INST_ADDR → addr_reg
  - INST_READ → rdata_reg
  - INST_STATUS → status
  - INST_WDATA → wdata_reg
  - else 0
- Registered mux output keeps capture quasi-static in the TCK domain.
- Host contract: poll INST_STATUS until busy=0 before issuing the next command or capturing read data.

## Timing
- Reset values: bus_req 0, bus_write 0, bus_addr 0, bus_wdata 0, jtag_dr_capture 0, busy 0. Internal addr/wdata/rdata registers, error, overrun and synchronizer all 0; FSM in IDLE.
- `cmd` pulse fires SYNC_STAGES+1 clk edges after jtag_dr_update rises.
- bus_req, bus_write, bus_addr, bus_wdata and busy are registered. They assert the cycle after `cmd` and are held constant until bus_ready.
- bus_req drops the cycle after the bus_ready sample.
- A response in the same cycle as bus_ready is not accepted; responses are counted only in WAIT.
- busy deasserts the cycle after the response is taken.
- jtag_dr_capture updates one clk after any source register or jtag_ir changes.
- TCK period must be ≥ (SYNC_STAGES+2) clk periods; otherwise update pulses may be lost.
- Async rst mid-transaction: all outputs clear immediately, including bus_req; the in-flight response is discarded.

## Structure
- Instruction codes and status bit positions belong in the shared JTAG memory-map offset header, next to JTAG_INST_IDCODE/BYPASS.
- FSM state encodings stay local.
- One sub-module is natural: `jtag_pulse_sync` (flop chain + edge detect, parameter SYNC_STAGES), reusable for a capture-strobe path.

## Test plan
- Write path: ADDR=0x1000_0000 then WDATA=0xDEADBEEF, bus_ready after 2 cycles, response OK → one write to 0x1000_0000 with 0xDEADBEEF; STATUS capture=0x0; ADDR capture=0x1000_0004.
- Read with auto-increment: ADDR=0x200, two READs returning 0x11 then 0x22 → bus_addr 0x200 then 0x204; READ capture shows 0x22 after the second read.
- Overrun: second update while bus_ready held low → no extra bus_req; status=0x5 (busy, overrun). STATUS update with bit0=1 after completion → status 0x0.
- Timeout: never assert bus_resp_valid → bus_req/busy drop after 1024 cycles; status=0x2; addr advanced by 4.
- Wrap and error: ADDR=0xFFFF_FFFC, READ with bus_resp_error=1 → status=0x2; ADDR capture=0x0000_0000.
- Reset mid-op: assert rst during WAIT → bus_req, busy and capture read 0 in the same cycle; next READ after release uses address 0.
